// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// instruction classes, ALU function codes, RAM access sizes, opcodes,
// funct codes and datapath select values.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF   = 5'd0,
        S_ID   = 5'd1,
        S_EX_R = 5'd2,
        S_EX_I = 5'd3,
        S_MA   = 5'd4,
        S_MR   = 5'd5,
        S_WB_L = 5'd6,
        S_MW   = 5'd7,
        S_WB_R = 5'd8,
        S_WB_I = 5'd9,
        S_BR   = 5'd10,
        S_J    = 5'd11,
        S_JAL  = 5'd12,
        S_JR   = 5'd13,
        S_TRAP = 5'd31
    } state_e;

    // Instruction classes produced by the decoder
    localparam logic [3:0] C_R    = 4'd0;
    localparam logic [3:0] C_JR   = 4'd1;
    localparam logic [3:0] C_ALUI = 4'd2;
    localparam logic [3:0] C_LD   = 4'd3;
    localparam logic [3:0] C_ST   = 4'd4;
    localparam logic [3:0] C_BEQ  = 4'd5;
    localparam logic [3:0] C_BNE  = 4'd6;
    localparam logic [3:0] C_J    = 4'd7;
    localparam logic [3:0] C_JAL  = 4'd8;
    localparam logic [3:0] C_ILL  = 4'd9;

    // ALU function codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    // RAM access size / extension
    localparam logic [2:0] RAM_W  = 3'd0;
    localparam logic [2:0] RAM_HS = 3'd1;
    localparam logic [2:0] RAM_HU = 3'd2;
    localparam logic [2:0] RAM_BS = 3'd3;
    localparam logic [2:0] RAM_BU = 3'd4;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Datapath select values
    localparam logic [1:0] PC_SRC_ALU  = 2'd0;
    localparam logic [1:0] PC_SRC_AOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JMP  = 2'd2;
    localparam logic [1:0] PC_SRC_RS   = 2'd3;
    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_RA  = 2'd2;
    localparam logic [1:0] M2R_AOUT    = 2'd0;
    localparam logic [1:0] M2R_MDR     = 2'd1;
    localparam logic [1:0] M2R_PC      = 2'd2;
    localparam logic [1:0] ALUB_B      = 2'd0;
    localparam logic [1:0] ALUB_4      = 2'd1;
    localparam logic [1:0] ALUB_SIMM   = 2'd2;
    localparam logic [1:0] ALUB_ZIMM   = 2'd3;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Instruction decoder: opcode/funct -> class, ALU function, RAM access size.
// Sub-word loads/stores are only recognised when MC_BYTE_ACCESS_EN is defined;
// otherwise they fall through to the illegal class and RAMCtrl stays 0.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] iclass,
    output logic       logic_imm,
    output logic [3:0] alu_op,
    output logic [2:0] ram_ctrl
);

    // Pure table lookup; everything not listed is illegal
    always_comb begin
        iclass    = C_ILL;
        logic_imm = 1'b0;
        alu_op    = ALU_ADD;
        ram_ctrl  = RAM_W;
        case (opcode)
            OP_RTYPE: begin
                iclass = (funct == FN_JR) ? C_JR : C_R;
                case (funct)
                    FN_SUB, FN_SUBU:  alu_op = ALU_SUB;
                    FN_AND:           alu_op = ALU_AND;
                    FN_OR:            alu_op = ALU_OR;
                    FN_XOR:           alu_op = ALU_XOR;
                    FN_NOR:           alu_op = ALU_NOR;
                    FN_SLT:           alu_op = ALU_SLT;
                    FN_SLTU:          alu_op = ALU_SLTU;
                    FN_SLL, FN_SLLV:  alu_op = ALU_SLL;
                    FN_SRL, FN_SRLV:  alu_op = ALU_SRL;
                    FN_SRA, FN_SRAV:  alu_op = ALU_SRA;
                    default:          alu_op = ALU_ADD;
                endcase
            end
            OP_ADDIU: iclass = C_ALUI;
            OP_SLTI:  begin iclass = C_ALUI; alu_op = ALU_SLT;  end
            OP_SLTIU: begin iclass = C_ALUI; alu_op = ALU_SLTU; end
            OP_ANDI:  begin iclass = C_ALUI; alu_op = ALU_AND; logic_imm = 1'b1; end
            OP_ORI:   begin iclass = C_ALUI; alu_op = ALU_OR;  logic_imm = 1'b1; end
            OP_XORI:  begin iclass = C_ALUI; alu_op = ALU_XOR; logic_imm = 1'b1; end
            OP_LUI:   begin iclass = C_ALUI; alu_op = ALU_LUI; end
            OP_LW:    iclass = C_LD;
            OP_SW:    iclass = C_ST;
            OP_BEQ:   begin iclass = C_BEQ; alu_op = ALU_SUB; end
            OP_BNE:   begin iclass = C_BNE; alu_op = ALU_SUB; end
            OP_J:     iclass = C_J;
            OP_JAL:   iclass = C_JAL;
`ifdef MC_BYTE_ACCESS_EN
            OP_LB:    begin iclass = C_LD; ram_ctrl = RAM_BS; end
            OP_LBU:   begin iclass = C_LD; ram_ctrl = RAM_BU; end
            OP_LH:    begin iclass = C_LD; ram_ctrl = RAM_HS; end
            OP_LHU:   begin iclass = C_LD; ram_ctrl = RAM_HU; end
            OP_SB:    begin iclass = C_ST; ram_ctrl = RAM_BS; end
            OP_SH:    begin iclass = C_ST; ram_ctrl = RAM_HS; end
`endif
            default:  iclass = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM. The state register is the only flop; every
// datapath strobe/select is a combinational decode of state, inst, zero and
// mem_ready, forced to 0 while rst is low. Optional sub-word memory access is
// enabled with MC_BYTE_ACCESS_EN.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [4:0]  state,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_r,
    output logic        mem_w,
    output logic        i_or_d,
    output logic        alu_src_a,
    output logic [1:0]  pc_src,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [2:0]  RAMCtrl,
    output logic        ill_inst
);

    state_e     state_q, state_d;
    logic [3:0] iclass;
    logic [3:0] dec_alu_op;
    logic [2:0] dec_ram;
    logic       logic_imm;
    logic       unused_inst;

    // Only opcode and funct steer control; the rest of IR is datapath-only
    assign unused_inst = ^inst[25:6];

    mc_ctrl_decode u_decode (
        .opcode    (inst[31:26]),
        .funct     (inst[5:0]),
        .iclass    (iclass),
        .logic_imm (logic_imm),
        .alu_op    (dec_alu_op),
        .ram_ctrl  (dec_ram)
    );

    // Next-state: memory states stall on mem_ready, TRAP is sticky
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:   if (mem_ready) state_d = S_ID;
            S_ID: begin
                case (iclass)
                    C_R:          state_d = S_EX_R;
                    C_JR:         state_d = S_JR;
                    C_ALUI:       state_d = S_EX_I;
                    C_LD, C_ST:   state_d = S_MA;
                    C_BEQ, C_BNE: state_d = S_BR;
                    C_J:          state_d = S_J;
                    C_JAL:        state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_EX_R: state_d = S_WB_R;
            S_EX_I: state_d = S_WB_I;
            S_MA:   state_d = (iclass == C_ST) ? S_MW : S_MR;
            S_MR:   if (mem_ready) state_d = S_WB_L;
            S_MW:   if (mem_ready) state_d = S_IF;
            S_WB_L, S_WB_R, S_WB_I, S_BR, S_J, S_JAL, S_JR: state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    // State register, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IF;
        else      state_q <= state_d;
    end

    assign state = state_q;

    // Output decode; gating on rst kills an in-flight RAM access instantly
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_AOUT;
        alu_src_b  = ALUB_B;
        alu_op     = ALU_ADD;
        RAMCtrl    = RAM_W;
        ill_inst   = 1'b0;
        if (rst) begin
            case (state_q)
                S_IF: begin
                    mem_r     = 1'b1;
                    alu_src_b = ALUB_4;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_ID:   alu_src_b = ALUB_SIMM;
                S_EX_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = dec_alu_op;
                end
                S_EX_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = logic_imm ? ALUB_ZIMM : ALUB_SIMM;
                    alu_op    = dec_alu_op;
                end
                S_MA: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_SIMM;
                    RAMCtrl   = dec_ram;
                end
                S_MR: begin
                    mem_r   = 1'b1;
                    i_or_d  = 1'b1;
                    RAMCtrl = dec_ram;
                end
                S_WB_L: begin
                    reg_we     = 1'b1;
                    mem_to_reg = M2R_MDR;
                    RAMCtrl    = dec_ram;
                end
                S_MW: begin
                    mem_w   = 1'b1;
                    i_or_d  = 1'b1;
                    RAMCtrl = dec_ram;
                end
                S_WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = REG_DST_RD;
                end
                S_WB_I: reg_we = 1'b1;
                S_BR: begin
                    alu_src_a = 1'b1;
                    alu_op    = dec_alu_op;
                    pc_src    = PC_SRC_AOUT;
                    pc_we     = (iclass == C_BEQ) ? zero : ~zero;
                end
                S_J: begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_JMP;
                end
                S_JAL: begin
                    pc_we      = 1'b1;
                    pc_src     = PC_SRC_JMP;
                    reg_we     = 1'b1;
                    reg_dst    = REG_DST_RA;
                    mem_to_reg = M2R_PC;
                end
                S_JR: begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_RS;
                end
                S_TRAP: ill_inst = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm. A per-instruction reference model expands each
// instruction into the list of states it must visit (with RAM wait cycles
// inserted) and the strobes each of those cycles must show.
// Honours MC_BYTE_ACCESS_EN the same way the design does.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic [4:0]  state;
    logic        pc_we, ir_we, reg_we, mem_r, mem_w, i_or_d, alu_src_a, ill_inst;
    logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0]  alu_op;
    logic [2:0]  RAMCtrl;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .state(state), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
        .mem_r(mem_r), .mem_w(mem_w), .i_or_d(i_or_d), .alu_src_a(alu_src_a),
        .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .RAMCtrl(RAMCtrl),
        .ill_inst(ill_inst)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t inst=%h)", tag, got, exp, $time, inst);
        end
    endtask

    // Instruction kinds of the reference model
    localparam int K_R = 0, K_JR = 1, K_ALUI = 2, K_LD = 3, K_ST = 4;
    localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

`ifdef MC_BYTE_ACCESS_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    function automatic int kind_of(input logic [31:0] i);
        case (i[31:26])
            6'h00: return (i[5:0] == 6'h08) ? K_JR : K_R;
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return K_ALUI;
            6'h23: return K_LD;
            6'h2B: return K_ST;
            6'h20, 6'h21, 6'h24, 6'h25: return BYTE_EN ? K_LD : K_ILL;
            6'h28, 6'h29: return BYTE_EN ? K_ST : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int ram_of(input logic [31:0] i);
        if (!BYTE_EN) return 0;
        case (i[31:26])
            6'h20, 6'h28: return 3;
            6'h24:        return 4;
            6'h21, 6'h29: return 1;
            6'h25:        return 2;
            default:      return 0;
        endcase
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    int exp_st[$];
    bit exp_rdy[$];

    task automatic push(input int s, input bit r);
        exp_st.push_back(s);
        exp_rdy.push_back(r);
    endtask

    // A RAM-facing state: w cycles of wait, then one completing cycle
    task automatic push_mem(input int s, input int w);
        int n;
        n = (w < 0) ? int'($urandom_range(0, 2)) : w;
        repeat (n) push(s, 1'b0);
        push(s, 1'b1);
    endtask

    task automatic build(input logic [31:0] i, input int wif, input int wmem);
        exp_st.delete();
        exp_rdy.delete();
        push_mem(0, wif);
        push(1, rb());
        case (kind_of(i))
            K_R:          begin push(2, rb()); push(8, rb()); end
            K_ALUI:       begin push(3, rb()); push(9, rb()); end
            K_LD:         begin push(4, rb()); push_mem(5, wmem); push(6, rb()); end
            K_ST:         begin push(4, rb()); push_mem(7, wmem); end
            K_BEQ, K_BNE: push(10, rb());
            K_J:          push(11, rb());
            K_JAL:        push(12, rb());
            K_JR:         push(13, rb());
            default:      push(31, rb());
        endcase
    endtask

    task automatic check_cycle(input int s, input logic [31:0] i, input logic z, input bit rdy);
        int  k, e_src, e_dst, e_m2r, e_ram;
        bit  e_pcwe, e_irwe, e_regwe, e_memr, e_memw;
        k       = kind_of(i);
        e_irwe  = (s == 0) && rdy;
        e_pcwe  = e_irwe || (s == 10 && ((k == K_BEQ) ? z : !z)) ||
                  s == 11 || s == 12 || s == 13;
        e_regwe = (s == 6) || (s == 8) || (s == 9) || (s == 12);
        e_memr  = (s == 0) || (s == 5);
        e_memw  = (s == 7);
        e_src   = (s == 10) ? 1 : (s == 11 || s == 12) ? 2 : (s == 13) ? 3 : 0;
        e_dst   = (s == 8) ? 1 : (s == 12) ? 2 : 0;
        e_m2r   = (s == 6) ? 1 : (s == 12) ? 2 : 0;
        e_ram   = (s >= 4 && s <= 7) ? ram_of(i) : 0;
        chk($sformatf("state"), state, s);
        chk($sformatf("pc_we@%0d", s), pc_we, e_pcwe);
        chk($sformatf("ir_we@%0d", s), ir_we, e_irwe);
        chk($sformatf("reg_we@%0d", s), reg_we, e_regwe);
        chk($sformatf("mem_r@%0d", s), mem_r, e_memr);
        chk($sformatf("mem_w@%0d", s), mem_w, e_memw);
        chk($sformatf("RAMCtrl@%0d", s), RAMCtrl, e_ram);
        chk($sformatf("ill_inst@%0d", s), ill_inst, s == 31);
        if (e_pcwe) chk($sformatf("pc_src@%0d", s), pc_src, e_src);
        if (e_regwe) begin
            chk($sformatf("reg_dst@%0d", s), reg_dst, e_dst);
            chk($sformatf("mem_to_reg@%0d", s), mem_to_reg, e_m2r);
        end
        if (e_memr || e_memw) chk($sformatf("i_or_d@%0d", s), i_or_d, s != 0);
        if (s == 0) chk("alu_src_b@IF", alu_src_b, 1);
        if (s == 3)
            chk("alu_src_b@EX_I", alu_src_b,
                (i[31:26] == 6'h0C || i[31:26] == 6'h0D || i[31:26] == 6'h0E) ? 3 : 2);
    endtask

    // Walk the expected path one cycle at a time; optionally stop inside a state
    task automatic run_path(input logic [31:0] i, input logic z, input int stop_at);
        inst = i;
        zero = z;
        for (int k = 0; k < exp_st.size(); k++) begin
            mem_ready = exp_rdy[k];
            #1;
            check_cycle(exp_st[k], i, z, exp_rdy[k]);
            if (exp_st[k] == stop_at) return;
            @(posedge clk); #1;
        end
    endtask

    task automatic trap_hold(input logic [31:0] i);
        repeat (3) begin
            mem_ready = rb();
            #1;
            check_cycle(31, i, zero, mem_ready);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_ir_we", ir_we, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_mem_r", mem_r, 0);
        chk("rst_mem_w", mem_w, 0);
        chk("rst_ill", ill_inst, 0);
        chk("rst_ram", RAMCtrl, 0);
        @(posedge clk); #1;
        chk("rst_state_hold", state, 0);
        rst = 1'b1;
        #1;
    endtask

    logic [5:0] ops [24] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09,
                             6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
                             6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h01, 6'h3F};
    logic [5:0] fns [12] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h08, 6'h08};

    initial begin
        logic [31:0] ri;
        logic        rz;

        do_reset();

        // addu: 0,1,2,8
        build(32'h00221821, 0, 0);
        run_path(32'h00221821, 1'b0, -1);
        // lw with two MR wait cycles: 0,1,4,5,5,5,6
        build(32'h8C080004, 0, 2);
        run_path(32'h8C080004, 1'b0, -1);
        // beq taken / not taken
        build(32'h10220003, 0, 0);
        run_path(32'h10220003, 1'b1, -1);
        build(32'h10220003, 0, 0);
        run_path(32'h10220003, 1'b0, -1);
        // jal
        build(32'h0C000010, 0, 0);
        run_path(32'h0C000010, 1'b0, -1);
        // lb: MA with RAMCtrl 3, or TRAP held until reset
        build(32'h80080000, 0, 0);
        run_path(32'h80080000, 1'b0, -1);
        if (!BYTE_EN) begin
            trap_hold(32'h80080000);
            do_reset();
        end

        // sw interrupted by reset inside MW
        build(32'hAC080000, 0, 1);
        run_path(32'hAC080000, 1'b0, 7);
        rst = 1'b0;
        #1;
        chk("mw_abort_mem_w", mem_w, 0);
        chk("mw_abort_mem_r", mem_r, 0);
        chk("mw_abort_state", state, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("post_rst_state", state, 0);
        chk("post_rst_mem_r", mem_r, 1);
        chk("post_rst_ir_we", ir_we, 0);

        // Random instruction stream with random RAM waits
        repeat (200) begin
            ri = $urandom;
            ri[31:26] = ops[$urandom_range(0, 23)];
            if (ri[31:26] == 6'h00) ri[5:0] = fns[$urandom_range(0, 11)];
            rz = rb();
            build(ri, -1, -1);
            run_path(ri, rz, -1);
            if (kind_of(ri) == K_ILL) begin
                trap_hold(ri);
                do_reset();
            end
        end

        mem_ready = 1'b0;
        #1;
        chk("final_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
